// File: rtl/mat_if_pkg.sv
// mat_if_pkg: shared widths, defaults, FSM states and 2x2 operand packing for the matrix job path
package mat_if_pkg;
    localparam int WIDTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 64;
    localparam int RES_W       = 64;
    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, ACK, HOLD} state_t;
    // element [r][c] sits at word index 3-(2r+c), so [0][0] occupies the MSBs
    function automatic int elem_lsb(input int r, input int c, input int w);
        return (3 - (2 * r + c)) * w;
    endfunction
endpackage

// File: rtl/mat_watchdog.sv
// mat_watchdog: wait-cycle counter that flags the last permitted cycle of an engine wait
module mat_watchdog
    import mat_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end
    assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mat_job_initiator.sv
// mat_job_initiator: hands 2x2 jobs to a matrix engine and returns the captured result to the host
module mat_job_initiator
    import mat_if_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid,
    input  logic [4*WIDTH-1:0] job_data,
    output logic               job_ready,
    output logic [4*WIDTH-1:0] mat_A,
    output logic               mat_start,
    input  logic               mat_done,
    input  logic [RES_W-1:0]   mat_res,
    output logic               mat_done_ack,
    output logic               res_valid,
    output logic [RES_W-1:0]   res_data,
    input  logic               res_ready,
    output logic               timeout_err,
    output logic [15:0]        jobs_done
);
    state_t state;
    logic   in_wait, expired;
    assign in_wait = (state == WAIT_DONE);
    mat_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_wait),
        .enable (in_wait),
        .expired(expired)
    );
    // a stale mat_done from an abandoned job must drain before a new start
    assign job_ready    = (state == IDLE) && !mat_done && !reset;
    assign mat_start    = (state == START);
    assign mat_done_ack = (state == ACK);
    assign res_valid    = (state == HOLD);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mat_A       <= '0;
            res_data    <= '0;
            jobs_done   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (job_valid && job_ready) begin
                    mat_A <= job_data;
                    state <= START;
                end
                START: state <= WAIT_DONE;
                WAIT_DONE: if (mat_done) begin
                    res_data <= mat_res;
                    state    <= ACK;
                end else if (expired) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end
                ACK: if (!mat_done) state <= HOLD;
                HOLD: if (res_ready) begin
                    jobs_done <= jobs_done + 16'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_job_initiator.sv
// tb_mat_job_initiator: randomized jobs against an engine stub and a result model
module tb_mat_job_initiator;
    localparam int W  = 8;
    localparam int TO = 16;
    logic          clk = 1'b0;
    logic          reset, job_valid, job_ready, mat_start, mat_done, mat_done_ack;
    logic          res_valid, res_ready, timeout_err;
    logic [4*W-1:0] job_data, mat_A;
    logic [63:0]   mat_res, res_data;
    logic [15:0]   jobs_done;
    int            total = 0, bad = 0;
    int            eng_lat = 0, eng_extra = 0, starts = 0, ack_cycles = 0;
    bit            eng_never = 0, eng_abort = 0;
    logic [15:0]   exp_jobs = 0;

    mat_job_initiator #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_data(job_data),
        .job_ready(job_ready), .mat_A(mat_A), .mat_start(mat_start), .mat_done(mat_done),
        .mat_res(mat_res), .mat_done_ack(mat_done_ack), .res_valid(res_valid),
        .res_data(res_data), .res_ready(res_ready), .timeout_err(timeout_err),
        .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // engine behaviour: every element passes through four +1 layers
    function automatic logic [63:0] ref_res(input logic [31:0] a);
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i*8 +: 8] + 8'd4;
        return r;
    endfunction

    initial begin : engine
        bit          pend = 0, hold = 0;
        int          cnt = 0, ext = 0;
        logic [31:0] op = '0;
        mat_done = 1'b0;
        mat_res  = '0;
        forever begin
            @(negedge clk);
            if (eng_abort) begin
                pend = 0; hold = 0; mat_done = 1'b0;
            end
            if (mat_start) begin
                chk("start_clear", {62'b0, mat_done, mat_done_ack}, 64'd0);
                starts++;
                ack_cycles = 0;
                op   = mat_A;
                pend = !eng_never;
                cnt  = eng_lat;
                ext  = eng_extra;
            end
            if (mat_done_ack) ack_cycles++;
            if (pend) begin
                if (cnt == 0) begin
                    pend = 0; hold = 1; mat_done = 1'b1; mat_res = ref_res(op);
                end else cnt--;
            end else if (hold && mat_done_ack) begin
                if (ext == 0) begin
                    hold = 0; mat_done = 1'b0;
                end else ext--;
            end
            if (!hold) mat_res = {$urandom, $urandom};
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!job_ready && n < 50) begin
            tick;
            n++;
        end
        chk("ready_wait", {63'b0, job_ready}, 64'd1);
    endtask

    task automatic run_job(input logic [31:0] d, input int lat, input int extra, input int rdly);
        int n = 0;
        int s0;
        wait_ready;
        s0 = starts;
        eng_lat = lat;
        eng_extra = extra;
        job_valid = 1'b1;
        job_data = d;
        tick;
        job_valid = 1'b0;
        job_data = $urandom;
        chk("mat_A", {32'b0, mat_A}, {32'b0, d});
        while (!res_valid && n < 80) begin
            tick;
            n++;
        end
        chk("res_valid", {63'b0, res_valid}, 64'd1);
        chk("res_data", res_data, ref_res(d));
        chk("one_start", 64'(starts - s0), 64'd1);
        for (int i = 0; i < rdly; i++) begin
            tick;
            chk("hold_flags", {61'b0, res_valid, job_ready, mat_start}, 64'd4);
            chk("hold_data", res_data, ref_res(d));
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        exp_jobs++;
        chk("released", {63'b0, res_valid}, 64'd0);
        chk("jobs_done", {48'b0, jobs_done}, {48'b0, exp_jobs});
        chk("mat_A_hold", {32'b0, mat_A}, {32'b0, d});
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation exceeded time limit");
    end

    initial begin
        reset = 1'b1; job_valid = 1'b0; job_data = '0; res_ready = 1'b0;
        tick;
        tick;
        chk("rst_flags", {59'b0, job_ready, mat_start, mat_done_ack, res_valid, timeout_err}, 64'd0);
        chk("rst_regs", {mat_A, jobs_done, 16'b0}, 64'd0);
        chk("rst_res", res_data, 64'd0);
        reset = 1'b0;
        tick;
        chk("idle_ready", {63'b0, job_ready}, 64'd1);
        run_job(32'h01020304, 2, 0, 0);
        chk("nominal_res", res_data, 64'h0000000005060708);
        run_job($urandom, 3, 1, 20);
        run_job($urandom, 1, 5, 1);
        chk("ack_len", 64'(ack_cycles), 64'd6);
        for (int j = 0; j < 30; j++)
            run_job($urandom, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        wait_ready;
        eng_never = 1;
        job_valid = 1'b1;
        job_data = $urandom;
        tick;
        job_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick;
            chk("to_wait", {62'b0, timeout_err, res_valid}, 64'd0);
        end
        tick;
        chk("timeout", {63'b0, timeout_err}, 64'd1);
        chk("to_idle", {63'b0, job_ready}, 64'd1);
        eng_never = 0;
        run_job($urandom, 4, 0, 2);
        chk("sticky", {63'b0, timeout_err}, 64'd1);
        force dut.jobs_done = 16'hFFFF;
        tick;
        release dut.jobs_done;
        exp_jobs = 16'hFFFF;
        chk("preload", {48'b0, jobs_done}, 64'hFFFF);
        run_job($urandom, 2, 0, 0);
        chk("wrap", {48'b0, jobs_done}, 64'd0);
        wait_ready;
        eng_lat = 8;
        job_valid = 1'b1;
        job_data = $urandom;
        tick;
        job_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("mid_rst_flags", {59'b0, job_ready, mat_start, mat_done_ack, res_valid, timeout_err}, 64'd0);
        chk("mid_rst_regs", {mat_A, jobs_done, 16'b0}, 64'd0);
        chk("mid_rst_res", res_data, 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("rst_no_ack", {62'b0, mat_done_ack, job_ready}, 64'd0);
        end
        reset = 1'b0;
        exp_jobs = 0;
        tick;
        chk("stale_done_block", {63'b0, job_ready}, 64'd0);
        eng_abort = 1;
        tick;
        eng_abort = 0;
        chk("ready_after_drain", {63'b0, job_ready}, 64'd1);
        run_job($urandom, 0, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
